// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, the frame generator state set and lane-packing helpers.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam logic [63:0] XGMII_IDLE_TXD = {8{XGMII_IDLE}};
    localparam logic [63:0] XGMII_PRE_TXD  = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        TERM = 3'd3,
        IPG  = 3'd4
    } xgmii_state_e;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
    } xgmii_word_t;

    // Eight consecutive payload bytes starting at 'first', lane 0 first.
    function automatic logic [63:0] data_word(input logic [7:0] first);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = first + 8'(i);
        end
        return w;
    endfunction

    // r tail bytes from 'tail' in lanes 0..r-1, terminate in lane r, idles above.
    // r = 0 yields the stand-alone terminate word.
    function automatic xgmii_word_t term_word(input logic [2:0] r, input logic [63:0] tail);
        xgmii_word_t w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(r)) begin
                w.txd[8*i +: 8] = tail[8*i +: 8];
            end else if (i == int'(r)) begin
                w.txd[8*i +: 8] = XGMII_TERM;
            end else begin
                w.txd[8*i +: 8] = XGMII_IDLE;
            end
        end
        w.txc = 8'hFF << r;
        return w;
    endfunction

endpackage

// File: rtl/xgmii_frame_gen.sv
// XGMII transmit frame generator: preamble, incrementing-byte payload, terminate, then a fixed idle gap.
//
// state | meaning (word currently on the wire)
// IDLE  | idle word, not busy, start accepted
// PRE   | start/preamble/SFD word
// DATA  | payload word; 'last' marks the final one, which may already carry the terminate
// TERM  | stand-alone terminate word (payload length multiple of 8)
// IPG   | forced idle words; ipg_cnt counts the ones still to follow
module xgmii_frame_gen
    import xgmii_pkg::*;
#(
    parameter int LEN_W     = 14,
    parameter int IPG_WORDS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       seed,
    output logic             busy,
    output logic             done,
    output logic [63:0]      xgmii_txd,
    output logic [7:0]       xgmii_txc
);

    localparam int IPG_CW = (IPG_WORDS > 1) ? $clog2(IPG_WORDS) : 1;
    localparam logic [IPG_CW-1:0] IPG_INIT = IPG_CW'(IPG_WORDS - 1);
    localparam logic [LEN_W-1:0]  WORD_BYTES = LEN_W'(8);

    xgmii_state_e      state, state_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic [7:0]        next_byte, next_byte_nxt;
    logic              last, last_nxt;
    logic [IPG_CW-1:0] ipg_cnt, ipg_cnt_nxt;
    xgmii_word_t       word_nxt;
    logic              done_nxt;

    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        next_byte_nxt = next_byte;
        last_nxt      = last;
        ipg_cnt_nxt   = ipg_cnt;
        word_nxt      = '{txd: XGMII_IDLE_TXD, txc: 8'hFF};
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt     = PRE;
                    rem_nxt       = len;
                    next_byte_nxt = seed;
                    last_nxt      = 1'b0;
                    word_nxt      = '{txd: XGMII_PRE_TXD, txc: 8'h01};
                end
            end

            PRE, DATA: begin
                if (last) begin
                    // a final word that already carried the terminate goes straight to the gap
                    if (done) begin
                        state_nxt   = IPG;
                        ipg_cnt_nxt = IPG_INIT;
                    end else begin
                        state_nxt = TERM;
                        word_nxt  = term_word(3'd0, '0);
                        done_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt     = DATA;
                    next_byte_nxt = next_byte + 8'd8;
                    if (rem > WORD_BYTES) begin
                        rem_nxt  = rem - WORD_BYTES;
                        word_nxt = '{txd: data_word(next_byte), txc: 8'h00};
                    end else begin
                        last_nxt = 1'b1;
                        if (rem[2:0] == 3'd0) begin
                            word_nxt = '{txd: data_word(next_byte), txc: 8'h00};
                        end else begin
                            word_nxt = term_word(rem[2:0], data_word(next_byte));
                            done_nxt = 1'b1;
                        end
                    end
                end
            end

            TERM: begin
                state_nxt   = IPG;
                ipg_cnt_nxt = IPG_INIT;
            end

            IPG: begin
                if (ipg_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    ipg_cnt_nxt = ipg_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            next_byte <= '0;
            last      <= 1'b0;
            ipg_cnt   <= '0;
            xgmii_txd <= XGMII_IDLE_TXD;
            xgmii_txc <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            next_byte <= next_byte_nxt;
            last      <= last_nxt;
            ipg_cnt   <= ipg_cnt_nxt;
            xgmii_txd <= word_nxt.txd;
            xgmii_txc <= word_nxt.txc;
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Scoreboard bench for xgmii_frame_gen: frames are modelled as a lane byte stream chopped into words.
module tb_xgmii_frame_gen;

    localparam int LEN_W     = 14;
    localparam int IPG_WORDS = 2;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        busy;
        logic        done;
    } exp_t;

    localparam exp_t IDLE_W = '{txd: 64'h0707070707070707, txc: 8'hFF, busy: 1'b0, done: 1'b0};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       seed = '0;
    logic             busy;
    logic             done;
    logic [63:0]      xgmii_txd;
    logic [7:0]       xgmii_txc;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    xgmii_frame_gen #(.LEN_W(LEN_W), .IPG_WORDS(IPG_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .xgmii_txd (xgmii_txd),
        .xgmii_txc (xgmii_txc)
    );

    always #5 clk = ~clk;

    // Reference: every wire lane of the frame as a (byte, control) stream, padded to whole words.
    task automatic push_frame(input int n, input logic [7:0] s);
        logic [7:0] lb[$];
        logic       lc[$];
        exp_t       e;
        int         nw;
        sb.push_back('{txd: 64'hD5555555555555FB, txc: 8'h01, busy: 1'b1, done: 1'b0});
        for (int i = 0; i < n; i++) begin
            lb.push_back(8'(int'(s) + i));
            lc.push_back(1'b0);
        end
        lb.push_back(8'hFD);
        lc.push_back(1'b1);
        while (lb.size() % 8 != 0) begin
            lb.push_back(8'h07);
            lc.push_back(1'b1);
        end
        nw = lb.size() / 8;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int l = 0; l < 8; l++) begin
                e.txd[8*l +: 8] = lb[8*w + l];
                e.txc[l]        = lc[8*w + l];
            end
            e.busy = 1'b1;
            e.done = (w == nw - 1);
            sb.push_back(e);
        end
        for (int i = 0; i < IPG_WORDS; i++) begin
            sb.push_back('{txd: 64'h0707070707070707, txc: 8'hFF, busy: 1'b1, done: 1'b0});
        end
        sb.push_back(IDLE_W);
    endtask

    // Monitor: every cycle the DUT presents a word; nothing pending means an idle word is due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) e = sb.pop_front();
            else e = IDLE_W;
            vectors++;
            if ({xgmii_txd, xgmii_txc, busy, done} != e) begin
                miscompares++;
                $display("FAIL wire_word t=%0t got txd=%h txc=%h busy=%b done=%b exp txd=%h txc=%h busy=%b done=%b",
                         $time, xgmii_txd, xgmii_txc, busy, done, e.txd, e.txc, e.busy, e.done);
            end
        end
    end

    // Called at negedge+1; the request is honoured only if the model has nothing left to emit.
    task automatic drive_start(input int n, input logic [7:0] s);
        start = 1'b1;
        len   = LEN_W'(n);
        seed  = s;
        if (sb.size() == 0 && n != 0) push_frame(n, s);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL idle_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic send(input int n, input logic [7:0] s);
        wait_idle();
        drive_start(n, s);
    endtask

    task automatic check_reset_now();
        vectors++;
        if ({xgmii_txd, xgmii_txc, busy, done} != IDLE_W) begin
            miscompares++;
            $display("FAIL async_reset got txd=%h txc=%h busy=%b done=%b exp txd=%h txc=%h busy=0 done=0",
                     xgmii_txd, xgmii_txc, busy, done, IDLE_W.txd, IDLE_W.txc);
        end
    endtask

    initial begin
        int l;
        #1;
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            #1;
            start = ~start;
            len   = LEN_W'($urandom_range(0, 100));
            seed  = 8'($urandom);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
        end

        send(8, 8'h00);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        drive_start(5, 8'h33);
        send(3, 8'hA0);
        send(10, 8'hFF);
        wait_idle();
        drive_start(0, 8'h44);
        repeat (3) begin
            @(negedge clk);
            #1;
        end

        send(64, 8'h5A);
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        sb.delete();
        #1;
        check_reset_now();
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        send(1, 8'h11);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) l = 8 * $urandom_range(1, 8);
            else l = $urandom_range(1, 100);
            send(l, 8'($urandom));
            if ($urandom_range(0, 2) == 0) drive_start($urandom_range(0, 50), 8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                #1;
            end
        end

        wait_idle();
        repeat (4) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
